// File: rtl/encoder8_serializer_pkg.sv
// Shared multdiv encoder constants and serializer state encoding.
// No logic here; widths pair with the 3-to-8 decoder on the other side.
package encoder8_serializer_pkg;

  localparam int ENC_IN_W  = 8;
  localparam int ENC_IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/encoder8_serializer_priority_encoder8.sv
// Combinational lowest-set-bit encoder with any/onehot flags; zero latency.
// No state and no handshake; idx is 0 when vec is all-zero.
module priority_encoder8
  import encoder8_serializer_pkg::*;
(
  input  logic [ENC_IN_W-1:0]  vec,
  output logic [ENC_IDX_W-1:0] idx,
  output logic                 any,
  output logic                 onehot
);

  // Scan from the top so the lowest set bit is the last assignment to win.
  always_comb begin
    idx = '0;
    for (int i = ENC_IN_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = i[ENC_IDX_W-1:0];
    end
  end

  assign any    = |vec;
  assign onehot = any && ((vec & (vec - ENC_IN_W'(1))) == '0);

endmodule

// File: rtl/encoder8_serializer.sv
// Serializes an 8-bit multi-hot vector into 3-bit indices, lowest first; first index one edge after accept.
// One vector in flight: in_ready low while emitting; outputs hold while out_ready is low.
module encoder8_serializer
  import encoder8_serializer_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ENC_IN_W-1:0]  in_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ENC_IDX_W-1:0] out_idx,
  output logic                 out_last,
  output logic                 out_none,
  output logic                 busy
);

  state_e              state_q, state_d;
  logic [ENC_IN_W-1:0] pending_q, pending_d;
  logic                zero_flag_q, zero_flag_d;

  logic [ENC_IDX_W-1:0] enc_idx;
  logic                 enc_any;
  logic                 enc_onehot;
  logic                 last_beat;

  priority_encoder8 u_penc (
    .vec    (pending_q),
    .idx    (enc_idx),
    .any    (enc_any),
    .onehot (enc_onehot)
  );

  // popcount(pending) <= 1; an all-zero vector is its own last beat.
  assign last_beat = !enc_any || enc_onehot;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      zero_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      zero_flag_q <= zero_flag_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    zero_flag_d = zero_flag_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          pending_d   = in_vec;
          zero_flag_d = (in_vec == '0);
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          pending_d = pending_q & ~(ENC_IN_W'(1) << enc_idx);
          if (last_beat) begin
            state_d     = IDLE;
            zero_flag_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs come from registers only, so nothing on the input side reaches them combinationally.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_idx   = '0;
    out_last  = 1'b0;
    out_none  = 1'b0;
    if (state_q == EMIT) begin
      in_ready  = 1'b0;
      out_valid = 1'b1;
      busy      = 1'b1;
      out_idx   = enc_idx;
      out_last  = last_beat;
      out_none  = zero_flag_q;
    end
  end

endmodule
